// File: rtl/xadc_pkg.sv
// Shared constants for the XADC scan/average block: channel map, DRP register
// addresses, Config1 sequencer mode and the scan state encoding.
package xadc_pkg;

  localparam logic [6:0] ADDR_CFG0       = 7'h40;
  localparam logic [6:0] ADDR_CFG1       = 7'h41;
  // Config1 SEQ[3:0] value selecting single-channel mode
  localparam logic [3:0] CFG1_SEQ_SINGLE = 4'b0011;

  typedef struct packed {
    logic [4:0] addr;  // XADC channel / data register address
    logic [3:0] mux;   // external analog mux code
  } ch_entry_t;

  // Logical channel i -> auxiliary input VAUX[i], external mux position i
  localparam ch_entry_t CH_TABLE [16] = '{
    '{addr: 5'h10, mux: 4'd0},  '{addr: 5'h11, mux: 4'd1},
    '{addr: 5'h12, mux: 4'd2},  '{addr: 5'h13, mux: 4'd3},
    '{addr: 5'h14, mux: 4'd4},  '{addr: 5'h15, mux: 4'd5},
    '{addr: 5'h16, mux: 4'd6},  '{addr: 5'h17, mux: 4'd7},
    '{addr: 5'h18, mux: 4'd8},  '{addr: 5'h19, mux: 4'd9},
    '{addr: 5'h1A, mux: 4'd10}, '{addr: 5'h1B, mux: 4'd11},
    '{addr: 5'h1C, mux: 4'd12}, '{addr: 5'h1D, mux: 4'd13},
    '{addr: 5'h1E, mux: 4'd14}, '{addr: 5'h1F, mux: 4'd15}
  };

  typedef enum logic [3:0] {
    IDLE, CFG1_RD, CFG1_WR, SEL_CH, CFG0_RD, CFG0_WR,
    SETTLE, CONV, WAIT_EOC, RD_DATA, EMIT, DONE
  } state_t;

endpackage

// File: rtl/xadc_drp_master.sv
// Single-outstanding DRP transaction engine: one-cycle den strobe, then waits
// for drdy or gives up after DRP_TMO cycles.
module xadc_drp_master #(
  parameter int unsigned DRP_TMO = 255
) (
  input  logic        clk200,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [15:0] wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic        timeout,
  output logic        den,
  output logic        dwe,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  input  logic        drdy,
  input  logic [15:0] do_out
);

  localparam int unsigned TW = (DRP_TMO > 1) ? $clog2(DRP_TMO + 1) : 1;

  logic          waiting;
  logic [TW-1:0] tmo_cnt;

  // Issue strobe, then track drdy / timeout for the one outstanding access
  always_ff @(posedge clk200) begin
    if (rst) begin
      waiting <= 1'b0;
      tmo_cnt <= '0;
      den     <= 1'b0;
      dwe     <= 1'b0;
      daddr   <= '0;
      di      <= '0;
      done    <= 1'b0;
      rdata   <= '0;
      timeout <= 1'b0;
    end else begin
      den     <= 1'b0;
      dwe     <= 1'b0;
      daddr   <= '0;
      di      <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      if (!waiting) begin
        if (req) begin
          den     <= 1'b1;
          dwe     <= we;
          daddr   <= addr;
          di      <= we ? wdata : '0;
          waiting <= 1'b1;
          tmo_cnt <= '0;
        end
      end else if (drdy) begin
        done    <= 1'b1;
        rdata   <= do_out;
        waiting <= 1'b0;
      end else if (tmo_cnt == TW'(DRP_TMO - 1)) begin
        timeout <= 1'b1;
        waiting <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_scan_avg.sv
// Scans the enabled logical channels through the XADC in single-channel mode,
// averaging 2^AVG_LOG2 conversions per channel and emitting one result each.
module xadc_scan_avg
  import xadc_pkg::*;
#(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned DRP_TMO    = 255
) (
  input  logic            clk200,
  input  logic            rst,
  input  logic            start,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            busy_xadc,
  input  logic            eoc,
  input  logic [4:0]      channel,
  input  logic            drdy,
  input  logic [15:0]     do_out,
  output logic [6:0]      daddr,
  output logic            den,
  output logic            dwe,
  output logic [15:0]     di,
  output logic            convst,
  output logic [3:0]      mux_select,
  output logic            res_valid,
  output logic [3:0]      res_ch,
  output logic [11:0]     res_data,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned ACC_W = 12 + AVG_LOG2;
  localparam int unsigned SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [4:0]  LAST_SAMP = 5'((1 << AVG_LOG2) - 1);

  state_t            state, nstate;
  logic              start_d, start_rise;
  logic [N_CH-1:0]   pend_mask, sel_oh;
  logic [3:0]        sel_idx, ch_idx;
  logic              sel_found;
  logic              first_done;
  logic [15:0]       cfg_data;
  logic [ACC_W-1:0]  acc;
  logic [4:0]        samp_cnt;
  logic [SW-1:0]     settle_cnt;
  logic              drp_pending;
  logic [4:0]        cur_addr;

  logic              drp_req, drp_we, drp_done, drp_timeout;
  logic [6:0]        drp_addr;
  logic [15:0]       drp_wdata, drp_rdata;

  assign start_rise = start & ~start_d;
  assign cur_addr   = CH_TABLE[ch_idx].addr;

  xadc_drp_master #(.DRP_TMO(DRP_TMO)) u_drp (
    .clk200  (clk200),
    .rst     (rst),
    .req     (drp_req),
    .we      (drp_we),
    .addr    (drp_addr),
    .wdata   (drp_wdata),
    .done    (drp_done),
    .rdata   (drp_rdata),
    .timeout (drp_timeout),
    .den     (den),
    .dwe     (dwe),
    .daddr   (daddr),
    .di      (di),
    .drdy    (drdy),
    .do_out  (do_out)
  );

  // Lowest pending channel, so disabled channels cost no cycles
  always_comb begin
    sel_idx   = '0;
    sel_oh    = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (pend_mask[i] && !sel_found) begin
        sel_idx   = 4'(i);
        sel_oh[i] = 1'b1;
        sel_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk200) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic; any DRP timeout aborts straight to DONE
  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (start_rise)
                  nstate = (ch_mask == '0) ? DONE : (first_done ? SEL_CH : CFG1_RD);
      CFG1_RD:  if (drp_timeout) nstate = DONE; else if (drp_done) nstate = CFG1_WR;
      CFG1_WR:  if (drp_timeout) nstate = DONE; else if (drp_done) nstate = SEL_CH;
      SEL_CH:   nstate = CFG0_RD;
      CFG0_RD:  if (drp_timeout) nstate = DONE; else if (drp_done) nstate = CFG0_WR;
      CFG0_WR:  if (drp_timeout) nstate = DONE; else if (drp_done) nstate = SETTLE;
      SETTLE:   if (!busy_xadc && settle_cnt == SW'(SETTLE_CYC - 1)) nstate = CONV;
      CONV:     if (!busy_xadc) nstate = WAIT_EOC;
      WAIT_EOC: if (eoc) nstate = (channel == cur_addr) ? RD_DATA : CONV;
      RD_DATA:  if (drp_timeout) nstate = DONE;
                else if (drp_done) nstate = (samp_cnt == LAST_SAMP) ? EMIT : CONV;
      EMIT:     nstate = (pend_mask != '0) ? SEL_CH : DONE;
      DONE:     nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end

  // Output decode; DRP requests are gated so each state issues exactly one
  always_comb begin
    drp_req   = 1'b0;
    drp_we    = 1'b0;
    drp_addr  = '0;
    drp_wdata = '0;
    convst    = 1'b0;
    res_valid = 1'b0;
    res_ch    = '0;
    res_data  = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      CFG1_RD: begin
        drp_req  = !drp_pending;
        drp_addr = ADDR_CFG1;
      end
      CFG1_WR: begin
        drp_req   = !drp_pending;
        drp_we    = 1'b1;
        drp_addr  = ADDR_CFG1;
        drp_wdata = {CFG1_SEQ_SINGLE, cfg_data[11:0]};
      end
      CFG0_RD: begin
        drp_req  = !drp_pending;
        drp_addr = ADDR_CFG0;
      end
      CFG0_WR: begin
        drp_req   = !drp_pending;
        drp_we    = 1'b1;
        drp_addr  = ADDR_CFG0;
        drp_wdata = {cfg_data[15:5], cur_addr};
      end
      CONV:    convst = !busy_xadc;
      RD_DATA: begin
        drp_req  = !drp_pending;
        drp_addr = {2'b00, cur_addr};
      end
      EMIT: begin
        res_valid = 1'b1;
        res_ch    = ch_idx;
        res_data  = acc[AVG_LOG2 +: 12];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Scan datapath: channel bookkeeping, register shadows, settle and averaging
  always_ff @(posedge clk200) begin
    if (rst) begin
      start_d     <= 1'b0;
      pend_mask   <= '0;
      ch_idx      <= '0;
      first_done  <= 1'b0;
      cfg_data    <= '0;
      acc         <= '0;
      samp_cnt    <= '0;
      settle_cnt  <= '0;
      drp_pending <= 1'b0;
      mux_select  <= '0;
      err         <= 1'b0;
    end else begin
      start_d <= start;
      if (drp_req)                         drp_pending <= 1'b1;
      else if (drp_done || drp_timeout)    drp_pending <= 1'b0;
      if (drp_timeout) err <= 1'b1;
      case (state)
        IDLE: begin
          acc      <= '0;
          samp_cnt <= '0;
          if (start_rise) pend_mask <= ch_mask;
        end
        CFG1_RD, CFG0_RD: if (drp_done) cfg_data <= drp_rdata;
        CFG1_WR: if (drp_done) first_done <= 1'b1;
        SEL_CH: begin
          ch_idx    <= sel_idx;
          pend_mask <= pend_mask & ~sel_oh;
        end
        CFG0_WR: if (drp_done) begin
          mux_select <= CH_TABLE[ch_idx].mux;
          settle_cnt <= '0;
        end
        // Settling must be uninterrupted: XADC activity restarts the count
        SETTLE: settle_cnt <= busy_xadc ? '0 : settle_cnt + 1'b1;
        RD_DATA: if (drp_done) begin
          acc      <= acc + ACC_W'(drp_rdata[15:4]);
          samp_cnt <= samp_cnt + 1'b1;
        end
        EMIT: begin
          acc      <= '0;
          samp_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_scan_avg.sv
// Scoreboard bench for xadc_scan_avg with a behavioural XADC/DRP model.
module tb_xadc_scan_avg;

  logic        clk200 = 1'b0;
  logic        rst, start;
  logic [7:0]  ch_mask;
  logic        busy_xadc, eoc;
  logic [4:0]  channel;
  logic        drdy;
  logic [15:0] do_out;
  logic [6:0]  daddr;
  logic        den, dwe;
  logic [15:0] di;
  logic        convst;
  logic [3:0]  mux_select;
  logic        res_valid;
  logic [3:0]  res_ch;
  logic [11:0] res_data;
  logic        busy, done, err;

  always #5 clk200 = ~clk200;

  xadc_scan_avg #(.N_CH(8), .AVG_LOG2(2), .SETTLE_CYC(64), .DRP_TMO(255)) dut (
    .clk200(clk200), .rst(rst), .start(start), .ch_mask(ch_mask),
    .busy_xadc(busy_xadc), .eoc(eoc), .channel(channel),
    .drdy(drdy), .do_out(do_out),
    .daddr(daddr), .den(den), .dwe(dwe), .di(di),
    .convst(convst), .mux_select(mux_select),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  int n_tests = 0, n_fail = 0;
  logic [23:0] exp_drp [$];   // {we, addr, wdata (0 for reads)}
  logic [15:0] exp_res [$];   // {res_ch, res_data}
  logic [15:0] samples [$];   // data-register read responses, in order
  logic [15:0] cfg0_reg, cfg1_reg;
  int convst_cnt = 0, den_cnt = 0, res_cnt = 0, cyc_now = 0, den40_cyc = 0;
  bit withhold40 = 0, wrong_next = 0, wr40_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [6:0] a);
    exp_drp.push_back({1'b0, a, 16'h0000});
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
    exp_drp.push_back({1'b1, a, d});
  endtask

  // One channel: Config0 read, Config0 write, four data reads, one result
  task automatic chan(input logic [15:0] cfg0_wr, input logic [4:0] a,
                      input logic [3:0] ch, input logic [11:0] avg);
    push_rd(7'h40);
    push_wr(7'h40, cfg0_wr);
    for (int k = 0; k < 4; k++) push_rd({2'b00, a});
    exp_res.push_back({ch, avg});
  endtask

  task automatic add_samples(input logic [15:0] s0, s1, s2, s3);
    samples.push_back(s0); samples.push_back(s1);
    samples.push_back(s2); samples.push_back(s3);
  endtask

  task automatic run_scan(input string tag, input logic [7:0] mask, output int lat);
    @(negedge clk200);
    ch_mask = mask;
    start   = 1'b1;
    @(negedge clk200);
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!done && lat < 4000) begin
      @(negedge clk200);
      lat++;
    end
    check({tag, "_done"}, done, 1);
    @(negedge clk200);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_drp_left"}, exp_drp.size(), 0);
    check({tag, "_res_left"}, exp_res.size(), 0);
  endtask

  // XADC + DRP slave model; also the DRP-side scoreboard
  initial begin : model
    int dcnt, ecnt;
    logic [15:0] resp;
    logic [23:0] obs;
    dcnt = 0; ecnt = 0; resp = '0;
    drdy = 1'b0; do_out = '0; eoc = 1'b0; channel = '0; busy_xadc = 1'b0;
    forever begin
      @(posedge clk200); #1;
      cyc_now++;
      drdy = 1'b0;
      eoc  = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin drdy = 1'b1; do_out = resp; end
      end
      if (ecnt > 0) begin
        busy_xadc = 1'b1;
        ecnt--;
        if (ecnt == 0) begin
          busy_xadc = 1'b0;
          eoc = 1'b1;
          channel = wrong_next ? 5'h05 : cfg0_reg[4:0];
          wrong_next = 0;
        end
      end
      if (convst === 1'b1) begin convst_cnt++; ecnt = 3; end
      if (den === 1'b1) begin
        den_cnt++;
        obs = {dwe, daddr, dwe ? di : 16'h0000};
        if (exp_drp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL drp_unexpected: got 0x%0h, expected no access", obs);
        end else check("drp_access", obs, exp_drp.pop_front());
        resp = '0;
        if (dwe) begin
          if (daddr == 7'h40) begin cfg0_reg = di; wr40_seen = 1; end
          else if (daddr == 7'h41) cfg1_reg = di;
        end else if (daddr == 7'h40) begin resp = cfg0_reg; den40_cyc = cyc_now; end
        else if (daddr == 7'h41) resp = cfg1_reg;
        else if (samples.size() > 0) resp = samples.pop_front();
        if (withhold40 && daddr == 7'h40 && !dwe) withhold40 = 0;
        else dcnt = 2;
      end
    end
  end

  // Result-side scoreboard
  initial begin : res_mon
    forever begin
      @(negedge clk200);
      if (res_valid === 1'b1) begin
        res_cnt++;
        if (exp_res.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL res_unexpected: got ch %0d data 0x%0h, expected none", res_ch, res_data);
        end else check("res_ch_data", {res_ch, res_data}, exp_res.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, diff, d0, r0, k;
    rst = 1'b1; start = 1'b0; ch_mask = '0;
    cfg0_reg = 16'h1200; cfg1_reg = 16'hA123;
    repeat (3) @(negedge clk200);
    check("rst_busy", busy, 0);
    check("rst_den", den, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_convst", convst, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_mux", mux_select, 0);
    rst = 1'b0;

    // First scan: Config1 setup, channels 0 and 2
    push_rd(7'h41); push_wr(7'h41, 16'h3123);
    chan(16'h1210, 5'h10, 4'd0, 12'h801);
    add_samples(16'h8000, 16'h8010, 16'h8020, 16'h8030);
    chan(16'h1212, 5'h12, 4'd2, 12'h801);
    add_samples(16'h8000, 16'h8010, 16'h8020, 16'h8030);
    convst_cnt = 0;
    run_scan("scan1", 8'h05, lat);
    check("scan1_convst", convst_cnt, 8);
    check("scan1_mux", mux_select, 2);
    check("scan1_err", err, 0);

    // Second scan: no Config1, first eoc on wrong channel, stray start ignored
    wrong_next = 1;
    chan(16'h1211, 5'h11, 4'd1, 12'h280);
    add_samples(16'h1000, 16'h2000, 16'h3000, 16'h4000);
    convst_cnt = 0;
    fork
      run_scan("scan2", 8'h02, lat);
      begin
        repeat (30) @(negedge clk200);
        start = 1'b1;
        @(negedge clk200);
        start = 1'b0;
      end
    join
    check("scan2_convst", convst_cnt, 5);
    check("scan2_mux", mux_select, 1);

    // Config0 read never answered -> timeout abort
    withhold40 = 1;
    push_rd(7'h40);
    run_scan("tmo", 8'h01, lat);
    diff = cyc_now - 1 - den40_cyc;
    check("tmo_err", err, 1);
    check("tmo_window", (diff >= 255 && diff <= 260), 1);

    // Normal scan after timeout; truncating average, err stays set
    chan(16'h1210, 5'h10, 4'd0, 12'h000);
    add_samples(16'h0010, 16'h0010, 16'h0010, 16'h0000);
    run_scan("post_tmo", 8'h01, lat);
    check("post_tmo_err", err, 1);

    // Reset in the middle of SETTLE
    push_rd(7'h40); push_wr(7'h40, 16'h1212);
    wr40_seen = 0;
    @(negedge clk200);
    ch_mask = 8'h04; start = 1'b1;
    @(negedge clk200);
    start = 1'b0;
    k = 0;
    while (!wr40_seen && k < 500) begin @(negedge clk200); k++; end
    check("settle_wr_seen", wr40_seen, 1);
    repeat (10) @(negedge clk200);
    check("settle_mux", mux_select, 2);
    check("settle_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk200);
    check("midrst_busy", busy, 0);
    check("midrst_den", den, 0);
    check("midrst_mux", mux_select, 0);
    check("midrst_err", err, 0);
    rst = 1'b0;
    check("midrst_drp_left", exp_drp.size(), 0);

    // First scan after reset repeats Config1 setup; full-scale average
    push_rd(7'h41); push_wr(7'h41, 16'h3123);
    chan(16'h1212, 5'h12, 4'd2, 12'hFFF);
    add_samples(16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0);
    convst_cnt = 0;
    run_scan("rescan", 8'h04, lat);
    check("rescan_convst", convst_cnt, 4);

    // Empty mask: done on the next cycle, no traffic
    d0 = den_cnt; r0 = res_cnt;
    run_scan("empty", 8'h00, lat);
    check("empty_latency", lat, 0);
    check("empty_den", den_cnt - d0, 0);
    check("empty_res", res_cnt - r0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
